// File: rtl/poly_sub_ctrl.sv
// Polynomial subtraction sequencer: streams coefficient pairs from RAM A/B into
// poly_sub_coeff at one pair per cycle and writes the in-order results to the result RAM.
module poly_sub_ctrl #(
  parameter int N      = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       ram_a_din,
  input  logic [15:0]       ram_b_din,
  output logic              co_start,
  output logic [15:0]       co_dia,
  output logic [15:0]       co_dib,
  input  logic              co_done,
  input  logic [15:0]       co_dout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_vld_q;
  logic                co_start_q;
  logic [15:0]         co_dia_q;
  logic [15:0]         co_dib_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [15:0]         wr_data_q;
  logic                busy_q;
  logic                done_q;
  logic                wr_fire_d;

  // A result is taken only while a run is in flight and fewer than N have been written.
  always_comb begin
    wr_fire_d = 1'b0;
    if (co_done && ((state_q == ISSUE) || (state_q == DRAIN)) && (wr_cnt_q != N_CNT)) begin
      wr_fire_d = 1'b1;
    end else begin
      wr_fire_d = 1'b0;
    end
  end

  // Run FSM: rd_cnt_q holds the next read address, so address 0 goes out on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            rd_cnt_q  <= CNT_ONE;
            wr_cnt_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (rd_cnt_q == N_CNT) begin
            state_q <= DRAIN;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= rd_cnt_q[ADDR_W-1:0];
            rd_cnt_q  <= rd_cnt_q + CNT_ONE;
          end
        end
        DRAIN: begin
          if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRAIN;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      wr_en_q <= wr_fire_d;
      if (wr_fire_d) begin
        wr_addr_q <= wr_cnt_q[ADDR_W-1:0];
        wr_data_q <= co_dout;
        wr_cnt_q  <= wr_cnt_q + CNT_ONE;
      end else begin
        wr_addr_q <= wr_addr_q;
      end
    end
  end

  // Read-return pipeline: RAM data lands one cycle after rd_en and is presented a cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q   <= 1'b0;
      co_start_q <= 1'b0;
      co_dia_q   <= 16'd0;
      co_dib_q   <= 16'd0;
    end else begin
      rd_vld_q   <= rd_en_q;
      co_start_q <= rd_vld_q;
      if (rd_vld_q) begin
        co_dia_q <= ram_a_din;
        co_dib_q <= ram_b_din;
      end else begin
        co_dia_q <= co_dia_q;
        co_dib_q <= co_dib_q;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign co_start = co_start_q;
  assign co_dia   = co_dia_q;
  assign co_dib   = co_dib_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Bench for poly_sub_ctrl: RAM and subtract-unit models around the DUT, with a
// run-level timing model (accept cycle plus fixed offsets) checked every cycle.
module tb_poly_sub_ctrl;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int Q  = 12289;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, co_start, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0]   ram_a_din = 16'd0, ram_b_din = 16'd0;
  logic [15:0]   co_dia, co_dib, wr_data;
  logic          co_done = 1'b0;
  logic [15:0]   co_dout = 16'd0;

  poly_sub_ctrl #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .ram_a_din(ram_a_din), .ram_b_din(ram_b_din),
    .co_start(co_start), .co_dia(co_dia), .co_dib(co_dib),
    .co_done(co_done), .co_dout(co_dout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  logic [15:0] res_mem [N];
  int  lat = 1;
  bit  spur = 1'b0;
  bit  in_rst = 1'b1;
  bit  active = 1'b0;
  int  acc = 0, done_c = 0, nwr = 0, wcnt = 0, ndone = 0;
  int  first_rd = -1, done_seen = -1;
  bit  prev_rd = 1'b0, prev_cd_live = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int          due_q[$];
  logic [15:0] dout_q[$];

  function automatic logic [15:0] sub_mod(input logic [15:0] a, input logic [15:0] b);
    int r;
    r = (int'(a) - int'(b) + Q) % Q;
    return 16'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);      chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_co_start"}, co_start, 0); chk({tag, "_co_dia"}, co_dia, 0);
    chk({tag, "_co_dib"}, co_dib, 0);    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);  chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);        chk({tag, "_done"}, done, 0);
  endtask

  // One clock cycle: check outputs against the run model, then drive the environment.
  task automatic step(input bit drv_start);
    int rel;
    bit e_rd, e_cs, e_wr, live;
    @(negedge clk);
    cyc++;
    if (in_rst) begin
      chk_all_zero("in_reset");
    end else begin
      rel  = active ? (cyc - acc) : -1;
      e_rd = active && (rel >= 1) && (rel <= N);
      chk("rd_en", rd_en, e_rd);
      if (e_rd && rd_en) chk("rd_addr", rd_addr, rel - 1);
      e_cs = active && (rel >= 3) && (rel <= N + 2);
      chk("co_start", co_start, e_cs);
      if (e_cs && co_start) begin
        chk("co_dia", co_dia, mem_a[rel-3]);
        chk("co_dib", co_dib, mem_b[rel-3]);
      end
      e_wr = prev_cd_live && (nwr < N);
      chk("wr_en", wr_en, e_wr);
      if (e_wr && wr_en) begin
        chk("wr_addr", wr_addr, nwr);
        chk("wr_data", wr_data, sub_mod(mem_a[nwr], mem_b[nwr]));
      end
      if (e_wr) nwr++;
      if (wr_en) begin
        res_mem[wr_addr] = wr_data;
        wcnt++;
      end
      chk("done", done, active && (cyc == done_c));
      chk("busy", busy, active && (cyc > acc) && (cyc < done_c));
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (done) begin
        done_seen = cyc;
        ndone++;
      end
    end

    if (prev_rd) begin
      ram_a_din = mem_a[prev_addr];
      ram_b_din = mem_b[prev_addr];
    end else begin
      ram_a_din = 16'($urandom);
      ram_b_din = 16'($urandom);
    end
    prev_rd   = rd_en && !in_rst;
    prev_addr = rd_addr;

    if (co_start && !in_rst) begin
      due_q.push_back(cyc + lat);
      dout_q.push_back(sub_mod(co_dia, co_dib));
    end
    live = active && (cyc > acc) && (cyc < done_c);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      co_done = 1'b1;
      co_dout = dout_q.pop_front();
      void'(due_q.pop_front());
    end else if (spur && !live && !in_rst) begin
      co_done = 1'b1;
      co_dout = 16'($urandom_range(0, Q - 1));
    end else begin
      co_done = 1'b0;
      co_dout = 16'($urandom_range(0, Q - 1));
    end
    prev_cd_live = co_done && live;

    start = drv_start;
    if (drv_start && !in_rst && (!active || cyc > done_c)) begin
      active = 1'b1; acc = cyc; done_c = cyc + N + lat + 4;
      nwr = 0; wcnt = 0; ndone = 0; first_rd = -1; done_seen = -1;
    end
  endtask

  task automatic do_reset_now();
    rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    in_rst = 1'b1; active = 1'b0; start = 1'b0;
    co_done = 1'b0; prev_cd_live = 1'b0; prev_rd = 1'b0;
    due_q.delete(); dout_q.delete();
  endtask

  // poke: 0 = no extra starts, 1 = start held every cycle, 2 = random starts.
  task automatic run(input int l, input bit sp, input int poke);
    bit s;
    lat = l; spur = sp;
    for (int i = 0; i < N; i++) res_mem[i] = 16'hffff;
    step(1'b1);
    for (int k = 0; k < N + l + 8 && cyc < done_c; k++) begin
      s = (poke == 1) ? 1'b1 : ((poke == 2) ? ($urandom_range(0, 3) == 0) : 1'b0);
      step(s);
    end
    start = 1'b0;
    chk("run_writes", wcnt, N);
    chk("run_done_pulses", ndone, 1);
    chk("run_done_latency", done_seen - first_rd, N + 2 + l + 1);
    for (int i = 0; i < N; i++) chk("run_result", res_mem[i], sub_mod(mem_a[i], mem_b[i]));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'(100 + i);
      mem_b[i] = 16'(i);
    end
    for (int i = 0; i < 3; i++) step(1'b0);
    rst = 1'b1; in_rst = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0);

    run(1, 1'b0, 0);
    for (int i = 0; i < N; i++) chk("pin_l1_result", res_mem[i], 32'd100);
    chk("pin_l1_latency", done_seen - first_rd, 32'd12);
    step(1'b0);

    run(3, 1'b0, 0);
    for (int i = 0; i < N; i++) chk("pin_l3_result", res_mem[i], 32'd100);
    chk("pin_l3_latency", done_seen - first_rd, 32'd14);
    step(1'b0);

    run(1, 1'b0, 1);
    step(1'b0);

    lat = 1; spur = 1'b0;
    step(1'b1);
    for (int k = 0; k < 40 && wcnt < 4; k++) step(1'b0);
    chk("pre_abort_writes", wcnt, 4);
    do_reset_now();
    for (int i = 0; i < 3; i++) step(1'b0);
    rst = 1'b1; in_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0);
    run(2, 1'b0, 0);
    step(1'b0);

    spur = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0);
    run(2, 1'b1, 0);
    spur = 1'b0;
    step(1'b0);

    run(1, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'd12288;
      mem_b[i] = 16'd12288;
    end
    run(2, 1'b0, 0);
    for (int i = 0; i < N; i++) chk("pin_b2b_zero", res_mem[i], 32'd0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        mem_a[i] = 16'($urandom_range(0, Q - 1));
        mem_b[i] = 16'($urandom_range(0, Q - 1));
      end
      spur = 1'($urandom_range(0, 1));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(1'b0);
      run(int'($urandom_range(1, 4)), spur, 2);
    end
    spur = 1'b0;
    step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
